// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the data-memory access unit: size codes,
// FSM state encoding, default word width and memory depth.
package mem_access_unit_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int RAM_SIZE   = 256;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_RD    = 3'd1,
    LD_CAP   = 3'd2,
    ST_RD    = 3'd3,
    ST_MERGE = 3'd4,
    ST_WR    = 3'd5,
    DONE     = 3'd6
  } state_t;

  // Alignment and size legality only; the range check needs the memory depth.
  function automatic logic align_fault(logic [1:0] size, logic [1:0] off);
    logic f;
    case (size)
      SIZE_BYTE: f = 1'b0;
      SIZE_HALF: f = off[0];
      SIZE_WORD: f = (off != 2'b00);
      default:   f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signals of the access unit.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
// req_* fields are don't-care otherwise, and resp_valid is a single-cycle pulse.
interface mem_access_unit_if #(parameter int WORD_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_fault;
  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling: load extraction with sign/zero extension and
// sub-word store merge into the previously read word.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int WORD_W = WORD_WIDTH
) (
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic              zext,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged
);

  logic [4:0]        shamt;
  logic [WORD_W-1:0] lane;
  logic [WORD_W-1:0] mask;

  always_comb begin
    shamt     = {off, 3'b000};
    lane      = word >> shamt;
    load_data = word;
    mask      = '1;
    case (size)
      SIZE_BYTE: begin
        load_data = {{(WORD_W-8){!zext && lane[7]}}, lane[7:0]};
        mask      = WORD_W'(8'hFF) << shamt;
      end
      SIZE_HALF: begin
        load_data = {{(WORD_W-16){!zext && lane[15]}}, lane[15:0]};
        mask      = WORD_W'(16'hFFFF) << shamt;
      end
      default: begin
        load_data = word;
        mask      = '1;
      end
    endcase
    merged = (word & ~mask) | ((wdata << shamt) & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: turns byte-addressed load/store requests into
// word-indexed memory accesses, with read-modify-write for sub-word stores.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WORD_W    = WORD_WIDTH,
  parameter int RAM_WORDS = RAM_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_unit_if.slave    bus,
  output state_t              state
);

  localparam logic [WORD_W-1:0] RAM_LIMIT = WORD_W'(RAM_WORDS);

  logic              req_ready_q;
  logic              resp_valid_q;
  logic [WORD_W-1:0] resp_rdata_q;
  logic              resp_fault_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [WORD_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q;

  // Request fields captured at accept; the request bus is ignored afterwards.
  logic [1:0]        size_q;
  logic              zext_q;
  logic [1:0]        off_q;
  logic [WORD_W-1:0] wdata_q;

  logic              accept;
  logic [WORD_W-1:0] word_idx;
  logic              req_fault;
  logic [WORD_W-1:0] load_data;
  logic [WORD_W-1:0] merged;

  assign accept    = bus.req_valid && req_ready_q;
  assign word_idx  = bus.req_addr >> 2;
  assign req_fault = align_fault(bus.req_size, bus.req_addr[1:0]) || (word_idx >= RAM_LIMIT);

  mem_lane_align #(.WORD_W(WORD_W)) u_align (
    .word      (bus.mem_rdata),
    .off       (off_q),
    .size      (size_q),
    .zext      (zext_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      size_q       <= '0;
      zext_q       <= 1'b0;
      off_q        <= '0;
      wdata_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready_q  <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
            size_q       <= bus.req_size;
            zext_q       <= bus.req_unsigned;
            off_q        <= bus.req_addr[1:0];
            wdata_q      <= bus.req_wdata;
            if (req_fault) begin
              resp_fault_q <= 1'b1;
              resp_valid_q <= 1'b1;
              state        <= DONE;
            end else begin
              mem_addr_q <= word_idx;
              if (!bus.req_write) begin
                mem_read_q <= 1'b1;
                state      <= LD_RD;
              end else if (bus.req_size == SIZE_WORD) begin
                mem_write_q <= 1'b1;
                mem_wdata_q <= bus.req_wdata;
                state       <= ST_WR;
              end else begin
                mem_read_q <= 1'b1;
                state      <= ST_RD;
              end
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        LD_RD: begin
          mem_read_q <= 1'b0;
          state      <= LD_CAP;
        end
        LD_CAP: begin
          resp_rdata_q <= load_data;
          resp_valid_q <= 1'b1;
          state        <= DONE;
        end
        ST_RD: begin
          mem_read_q <= 1'b0;
          state      <= ST_MERGE;
        end
        // Old word is on mem_rdata now; the merged word goes out next cycle.
        ST_MERGE: begin
          mem_wdata_q <= merged;
          mem_write_q <= 1'b1;
          state       <= ST_WR;
        end
        ST_WR: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory model, vector table with per-cycle
// strobe/latency expectations, response scoreboard and corner sequences.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int W  = 32;
  localparam int RW = 256;

  typedef struct {
    string        name;
    logic         wr;
    logic [1:0]   size;
    logic         uns;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic         fault;
    logic [W-1:0] rdata;
    int           lat;
    int           rd_cyc;
    int           wr_cyc;
    logic [W-1:0] mwdata;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst;
  state_t state;
  int     checks = 0;
  int     errors = 0;
  int     rd_strobes = 0;
  int     wr_strobes = 0;
  int     cyc = 0;
  logic [W:0]   exp_q[$];
  vec_t         vq[$];
  logic [W-1:0] ram [RW] = '{default: '0};
  logic [W-1:0] b2b_data [10];

  mem_access_unit_if #(.WORD_W(W)) bus();

  mem_access_unit #(.WORD_W(W), .RAM_WORDS(RW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .state (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- data memory model: one-cycle read latency ----------------
  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_addr < RW) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    if (bus.mem_read && bus.mem_addr < RW) bus.mem_rdata <= ram[bus.mem_addr[7:0]];
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst) begin
      if (bus.mem_read) rd_strobes++;
      if (bus.mem_write) wr_strobes++;
      check("strobe_exclusive", {31'b0, bus.mem_read & bus.mem_write}, '0);
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid with empty queue, required none");
        end else begin
          e = exp_q.pop_front();
          check("resp_fault", {31'b0, bus.resp_fault}, {31'b0, e[W]});
          check("resp_rdata", bus.resp_rdata, e[W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic vec_t mk(string name, logic wr, logic [1:0] size, logic uns,
                              logic [W-1:0] addr, logic [W-1:0] wdata, logic fault,
                              logic [W-1:0] rdata, int lat, int rd_cyc, int wr_cyc,
                              logic [W-1:0] mwdata);
    vec_t v;
    v.name = name; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.fault = fault; v.rdata = rdata; v.lat = lat;
    v.rd_cyc = rd_cyc; v.wr_cyc = wr_cyc; v.mwdata = mwdata;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s.ready", name), {31'b0, bus.req_ready}, 1);
  endtask

  task automatic run_req(input vec_t v);
    int k = 0;
    int rd_c = 0;
    int wr_c = 0;
    logic [W-1:0] wd = '0;
    logic [W-1:0] ma = '0;
    wait_ready(v.name);
    bus.req_write    = v.wr;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_valid    = 1'b1;
    exp_q.push_back({v.fault, v.rdata});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.mem_read && rd_c == 0) begin rd_c = c; ma = bus.mem_addr; end
      if (bus.mem_write && wr_c == 0) begin wr_c = c; wd = bus.mem_wdata; ma = bus.mem_addr; end
      if (bus.resp_valid) begin k = c; break; end
    end
    check($sformatf("%s.latency", v.name), k, v.lat);
    check($sformatf("%s.rd_cycle", v.name), rd_c, v.rd_cyc);
    check($sformatf("%s.wr_cycle", v.name), wr_c, v.wr_cyc);
    check($sformatf("%s.mem_wdata", v.name), wd, v.mwdata);
    check($sformatf("%s.mem_addr", v.name), ma, v.fault ? '0 : (v.addr >> 2));
    check($sformatf("%s.state", v.name), {29'b0, state}, {29'b0, DONE});
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, ".req_ready"},  {31'b0, bus.req_ready}, 0);
    check({name, ".resp_valid"}, {31'b0, bus.resp_valid}, 0);
    check({name, ".resp_rdata"}, bus.resp_rdata, 0);
    check({name, ".resp_fault"}, {31'b0, bus.resp_fault}, 0);
    check({name, ".mem_read"},   {31'b0, bus.mem_read}, 0);
    check({name, ".mem_write"},  {31'b0, bus.mem_write}, 0);
    check({name, ".mem_addr"},   bus.mem_addr, 0);
    check({name, ".mem_wdata"},  bus.mem_wdata, 0);
    check({name, ".state"},      {29'b0, state}, {29'b0, IDLE});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int wr0;
    int last_acc;
    int n;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    //               name        wr size uns addr        wdata         flt rdata         lat rd wr mwdata
    vq.push_back(mk("sw_10",    1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0,        2, 0, 1, 32'hDEADBEEF));
    vq.push_back(mk("lb_13",    0, 2'b00, 0, 32'h13,  32'h0,        0, 32'hFFFFFFDE, 3, 1, 0, 32'h0));
    vq.push_back(mk("lbu_13",   0, 2'b00, 1, 32'h13,  32'h0,        0, 32'h000000DE, 3, 1, 0, 32'h0));
    vq.push_back(mk("lh_12",    0, 2'b01, 0, 32'h12,  32'h0,        0, 32'hFFFFDEAD, 3, 1, 0, 32'h0));
    vq.push_back(mk("lhu_10",   0, 2'b01, 1, 32'h10,  32'h0,        0, 32'h0000BEEF, 3, 1, 0, 32'h0));
    vq.push_back(mk("lw_10a",   0, 2'b10, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 3, 1, 0, 32'h0));
    vq.push_back(mk("sb_11",    1, 2'b00, 0, 32'h11,  32'h12345655, 0, 32'h0,        4, 1, 3, 32'hDEAD55EF));
    vq.push_back(mk("lw_10b",   0, 2'b10, 0, 32'h10,  32'h0,        0, 32'hDEAD55EF, 3, 1, 0, 32'h0));
    vq.push_back(mk("sh_12",    1, 2'b01, 0, 32'h12,  32'hAAAA1234, 0, 32'h0,        4, 1, 3, 32'h123455EF));
    vq.push_back(mk("lw_10c",   0, 2'b10, 0, 32'h10,  32'h0,        0, 32'h123455EF, 3, 1, 0, 32'h0));
    vq.push_back(mk("lb_10",    0, 2'b00, 0, 32'h10,  32'h0,        0, 32'hFFFFFFEF, 3, 1, 0, 32'h0));
    vq.push_back(mk("lh_12p",   0, 2'b01, 0, 32'h12,  32'h0,        0, 32'h00001234, 3, 1, 0, 32'h0));
    vq.push_back(mk("f_sh_11",  1, 2'b01, 0, 32'h11,  32'h5555,     1, 32'h0,        1, 0, 0, 32'h0));
    vq.push_back(mk("f_lw_12",  0, 2'b10, 0, 32'h12,  32'h0,        1, 32'h0,        1, 0, 0, 32'h0));
    vq.push_back(mk("f_size11", 0, 2'b11, 0, 32'h10,  32'h0,        1, 32'h0,        1, 0, 0, 32'h0));
    vq.push_back(mk("f_range",  0, 2'b10, 0, RW*4,    32'h0,        1, 32'h0,        1, 0, 0, 32'h0));
    vq.push_back(mk("sw_top",   1, 2'b10, 0, 32'h3FC, 32'hA5A55A5A, 0, 32'h0,        2, 0, 1, 32'hA5A55A5A));
    vq.push_back(mk("lw_top",   0, 2'b10, 0, 32'h3FC, 32'h0,        0, 32'hA5A55A5A, 3, 1, 0, 32'h0));
    vq.push_back(mk("sb_3ff",   1, 2'b00, 0, 32'h3FF, 32'hFFFFFF80, 0, 32'h0,        4, 1, 3, 32'h80A55A5A));
    vq.push_back(mk("lb_3ff",   0, 2'b00, 0, 32'h3FF, 32'h0,        0, 32'hFFFFFF80, 3, 1, 0, 32'h0));
    vq.push_back(mk("lbu_3ff",  0, 2'b00, 1, 32'h3FF, 32'h0,        0, 32'h00000080, 3, 1, 0, 32'h0));

    // Reset state, then ready one cycle after release.
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("reset.ready_after", {31'b0, bus.req_ready}, 1);

    foreach (vq[i]) run_req(vq[i]);

    // Request held valid with changing fields while busy: only the first is taken.
    wait_ready("busy");
    bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h10; bus.req_wdata = '0; bus.req_valid = 1'b1;
    exp_q.push_back({1'b0, 32'h123455EF});
    @(posedge clk);
    wr0 = wr_strobes;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      bus.req_write = 1'b1;
      bus.req_size  = 2'($urandom_range(0, 2));
      bus.req_addr  = 32'h0;
      bus.req_wdata = $urandom();
    end
    @(negedge clk);
    check("busy.resp_cycle3", {31'b0, bus.resp_valid}, 1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("busy.no_write", wr_strobes, wr0);
    check("busy.word0", ram[0], 0);

    // Preload words 20..29, then back-to-back loads with req_valid held high.
    for (int i = 0; i < 10; i++) begin
      b2b_data[i] = $urandom();
      run_req(mk($sformatf("pre_%0d", i), 1, 2'b10, 0, (20 + i) * 4, b2b_data[i],
                 0, 32'h0, 2, 0, 1, b2b_data[i]));
    end
    last_acc = 0;
    for (int i = 0; i < 10; i++) begin
      bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
      bus.req_addr = (20 + i) * 4; bus.req_valid = 1'b1;
      wait_ready($sformatf("b2b_%0d", i));
      @(posedge clk);
      exp_q.push_back({1'b0, b2b_data[i]});
      #1;
      if (i > 0) check($sformatf("b2b_%0d.gap", i), cyc - last_acc, 4);
      last_acc = cyc;
    end
    bus.req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b.drained", exp_q.size(), 0);

    // Reset during ST_MERGE of a byte store aborts it without a write.
    wait_ready("abort");
    bus.req_write = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h11; bus.req_wdata = 32'h00000077; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort.st_rd", {29'b0, state}, {29'b0, ST_RD});
    @(negedge clk);
    check("abort.st_merge", {29'b0, state}, {29'b0, ST_MERGE});
    wr0 = wr_strobes;
    #1 rst = 1'b1;
    #1 check_outputs_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort.ready_after", {31'b0, bus.req_ready}, 1);
    check("abort.no_write", wr_strobes, wr0);
    check("abort.word4", ram[4], 32'h123455EF);
    run_req(mk("lw_after_abort", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h123455EF, 3, 1, 0, 32'h0));

    @(negedge clk);
    @(negedge clk);
    check("final.queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface; sits in the pipeline MEM stage between the load/store datapath and the word-addressed data memory.
- Accepts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests and converts them to word-index accesses on mem_read/mem_write/mem_addr/mem_wdata/mem_rdata.
- Performs read-modify-write for sub-word stores, lane extraction and extension for loads, and alignment/range checking.
- Sequencing is a small FSM with a ready/valid request side and a one-cycle response pulse.

Parameters:
WORD_W, `WORD_WIDTH (32), data/address width
RAM_WORDS, `RAM_SIZE, number of memory words; a word index >= RAM_WORDS faults

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; accept = req_valid && req_ready at a clk edge
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads: zero-extend (1) or sign-extend (0)
req_addr  in  WORD_W  byte address
req_wdata  in  WORD_W  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  WORD_W  extended load data; 0 for stores and faults
resp_fault  out  1  valid with resp_valid; misaligned, illegal size or out of range
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  WORD_W  word index = req_addr >> 2, zero-extended
mem_wdata  out  WORD_W  full word to write
mem_rdata  in  WORD_W  memory read data, valid the cycle after mem_read is sampled

Behaviour:
- Reset: all outputs 0 and state IDLE, applied immediately on rst. req_ready goes high after rst deasserts.
- All outputs are registered or decoded directly from state registers. There are no combinational paths from req_* to mem_*.
- mem_read and mem_write are never high together. Outside the access states both are 0. mem_addr and mem_wdata hold their last values.
- Request fields are latched at accept. req_* is ignored while req_ready is low.
- Little-endian lanes: byte b = addr[1:0] occupies bits [8b+7:8b]. Half h = addr[1] occupies bits [16h+15:16h].
- Fault check at accept:
  - size 11 is a fault.
  - half with addr[0] = 1 is a fault.
  - word with addr[1:0] != 0 is a fault.
  - word index >= RAM_WORDS is a fault.
  - A faulting request goes straight to DONE with resp_fault = 1 and never raises mem_read or mem_write.
- States: IDLE, LD_RD, LD_CAP, ST_RD, ST_MERGE, ST_WR, DONE.
- Transitions, where cycle k is the cycle after edge k and accept happens at edge 0:
  - Load: IDLE -> LD_RD (cycle 1, mem_read = 1) -> LD_CAP (cycle 2, extract lane from mem_rdata into resp_rdata) -> DONE (cycle 3).
  - SW: IDLE -> ST_WR (cycle 1, mem_write = 1, mem_wdata = req_wdata) -> DONE (cycle 2).
  - SB/SH: IDLE -> ST_RD (cycle 1, mem_read = 1) -> ST_MERGE (cycle 2, merge the req_wdata low lane into mem_rdata) -> ST_WR (cycle 3) -> DONE (cycle 4).
  - Fault: IDLE -> DONE (cycle 1).
- DONE: resp_valid = 1 for exactly one cycle, req_ready = 0, then IDLE. The next request can be accepted at the edge ending the first IDLE cycle.
- resp_rdata and resp_fault hold until the next DONE and are cleared at accept.
- Reset mid-operation aborts the access:
  - Reset asserted in ST_RD, ST_MERGE or earlier: no write is issued.
  - Reset asserted during ST_WR: the write is not guaranteed.
  - No resp_valid is produced for an aborted access.

Decomposition:
- Shared defines: size codes, state encodings, `WORD_WIDTH, `RAM_SIZE.
- One combinational sub-module mem_lane_align:
  - Load path: extract + sign/zero extend from (word, offset, size, unsigned).
  - Store path: merge from (old word, new data, offset, size).
  - The FSM and registers stay in mem_access_unit.

Test Plan:
- Bench pairs the unit with the team data-memory model.
- SW 0x10 / 0xDEADBEEF after reset -> cycle 1: mem_write=1, mem_addr=4, mem_wdata=0xDEADBEEF; cycle 2: resp_valid=1, fault=0.
- Loads from word 4 (= 0xDEADBEEF):
  - LB 0x13 -> resp_rdata 0xFFFFFFDE in cycle 3.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x10 -> 0x0000BEEF.
  - LW 0x10 -> 0xDEADBEEF.
- SB 0x11 data 0x12345655 -> mem_read in cycle 1, mem_write with 0xDEAD55EF in cycle 3, resp_valid in cycle 4; following LW 0x10 -> 0xDEAD55EF. SH 0x12 data 0xAAAA1234 -> 0x123455EF.
- Faults: each of the following -> resp_fault=1, resp_valid in cycle 1, no mem strobe ever:
  - SH 0x11
  - LW 0x12
  - size 11
  - LW (RAM_WORDS*4)
- req_valid held high with changing fields while busy -> only the first is accepted; 10 back-to-back LWs complete with one IDLE gap each, with correct data.
- rst pulsed during ST_MERGE of SB -> outputs 0 at once, no mem_write, memory word unchanged; req_ready=1 the cycle after rst falls.
